// File: rtl/key_press_classifier.sv
// Push-button front end for the LED shifter: synchronise, debounce, time each press
// in whole seconds, classify the release into a shift command and emit a 1 Hz step tick.
module key_press_classifier #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LEFT_SEC     = 3,
    parameter int RIGHT_SEC    = 5
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       KEY,
    output logic       tick_1hz,
    output logic       key_down,
    output logic [3:0] press_sec,
    output logic [1:0] mode,
    output logic       mode_valid
);

    localparam int SEC_W = $clog2(CLK_HZ);
    localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESSED = 1'b1
    } state_t;

    logic             sync1_r;
    logic             sync2_r;
    logic [DB_W-1:0]  db_cnt_r;
    logic             key_down_r;
    logic [SEC_W-1:0] tick_cnt_r;
    logic             tick_r;
    state_t           state_r;
    state_t           state_s;
    logic [SEC_W-1:0] sub_cnt_r;
    logic [SEC_W-1:0] sub_cnt_s;
    logic [3:0]       press_sec_r;
    logic [3:0]       press_sec_s;
    logic [3:0]       sec_adv_s;
    logic             sub_wrap_s;
    logic [1:0]       mode_r;
    logic [1:0]       mode_s;
    logic             mode_valid_r;
    logic             mode_valid_s;

    function automatic logic [1:0] classify(input logic [3:0] sec);
        logic [1:0] result;
        if (sec >= 4'(RIGHT_SEC)) begin
            result = MODE_RIGHT;
        end else if (sec >= 4'(LEFT_SEC)) begin
            result = MODE_LEFT;
        end else begin
            result = MODE_HOLD;
        end
        return result;
    endfunction

    // Two-flop synchroniser; resets to the released (high) level.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= KEY;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: count consecutive samples disagreeing with the accepted level, toggle when enough.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            db_cnt_r   <= '0;
            key_down_r <= 1'b0;
        end else if (sync2_r == ~key_down_r) begin
            db_cnt_r   <= '0;
        end else if (db_cnt_r == DB_W'(DEBOUNCE_CYC - 1)) begin
            db_cnt_r   <= '0;
            key_down_r <= ~key_down_r;
        end else begin
            db_cnt_r   <= db_cnt_r + {{(DB_W-1){1'b0}}, 1'b1};
        end
    end

    // Free-running 1 Hz divider; the pulse is pre-decoded so it lines up with the terminal count.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            tick_cnt_r <= '0;
            tick_r     <= 1'b0;
        end else if (tick_cnt_r == SEC_W'(CLK_HZ - 1)) begin
            tick_cnt_r <= '0;
            tick_r     <= 1'b0;
        end else begin
            tick_cnt_r <= tick_cnt_r + {{(SEC_W-1){1'b0}}, 1'b1};
            tick_r     <= (tick_cnt_r == SEC_W'(CLK_HZ - 2));
        end
    end

    // Press timer advance; a wrap on the release cycle is counted before classification.
    always_comb begin
        sub_wrap_s = (sub_cnt_r == SEC_W'(CLK_HZ - 1));
        sec_adv_s  = press_sec_r;
        if (sub_wrap_s && (press_sec_r != 4'd15)) begin
            sec_adv_s = press_sec_r + 4'd1;
        end else begin
            sec_adv_s = press_sec_r;
        end
    end

    // Press FSM next-state and registered-output values.
    always_comb begin
        state_s      = state_r;
        sub_cnt_s    = sub_cnt_r;
        press_sec_s  = press_sec_r;
        mode_s       = mode_r;
        mode_valid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (key_down_r) begin
                    state_s     = ST_PRESSED;
                    sub_cnt_s   = '0;
                    press_sec_s = 4'd0;
                end else begin
                    state_s     = ST_IDLE;
                end
            end
            ST_PRESSED: begin
                sub_cnt_s   = sub_wrap_s ? '0 : sub_cnt_r + {{(SEC_W-1){1'b0}}, 1'b1};
                press_sec_s = sec_adv_s;
                if (!key_down_r) begin
                    state_s      = ST_IDLE;
                    mode_s       = classify(sec_adv_s);
                    mode_valid_s = 1'b1;
                end else begin
                    state_s      = ST_PRESSED;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Press FSM state and output registers.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_r      <= ST_IDLE;
            sub_cnt_r    <= '0;
            press_sec_r  <= 4'd0;
            mode_r       <= MODE_HOLD;
            mode_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            sub_cnt_r    <= sub_cnt_s;
            press_sec_r  <= press_sec_s;
            mode_r       <= mode_s;
            mode_valid_r <= mode_valid_s;
        end
    end

    assign tick_1hz   = tick_r;
    assign key_down   = key_down_r;
    assign press_sec  = press_sec_r;
    assign mode       = mode_r;
    assign mode_valid = mode_valid_r;

endmodule
